// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 16x8 memory front end: defaults, state encoding
// and the bus turnaround length.
package mem_bus_pkg;

    localparam int AW_DEF      = 4;
    localparam int DW_DEF      = 8;
    localparam int RDLAT_DEF   = 1;
    localparam int TURN_CYCLES = 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_TURN     = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_RD_HOLD  = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        WR       = ST_WR,
        TURN     = ST_TURN,
        RD_ISSUE = ST_RD_ISSUE,
        RD_WAIT  = ST_RD_WAIT,
        RD_HOLD  = ST_RD_HOLD
    } state_e;

endpackage

// File: rtl/mem_bus_tristate.sv
// Write-side driver of the shared memory data bus: registered write enable and
// data, released to high impedance whenever no write is in progress.
module mem_bus_tristate
    import mem_bus_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_start_i,
    input  logic [DW-1:0] wdata_i,
    output logic          we_o,
    inout  wire  [DW-1:0] mem_data_io
);

    logic          we_q;
    logic [DW-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            we_q <= wr_start_i;
            if (wr_start_i) begin
                dout_q <= wdata_i;
            end
        end
    end

    assign we_o        = we_q;
    assign mem_data_io = we_q ? dout_q : {DW{1'bz}};

endmodule

// File: rtl/mem_bus_ctrl.sv
// Request/response controller for the 16x8 memory: single-word writes and
// 1..16 beat wrapping burst reads with response backpressure.
//
// state    | meaning
// IDLE     | req_ready high, waiting for a request
// WR       | mem_we high for one cycle with address and data
// TURN     | bus turnaround, we=oe=0
// RD_ISSUE | first beat: oe and start address driven at exit
// RD_WAIT  | waiting for read data, captured into the response register
// RD_HOLD  | beat presented; oe and address frozen until rsp_ready
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int RDLAT = RDLAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,
    output logic          busy,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [AW-1:0] mem_addr,
    inout  wire  [DW-1:0] mem_data
);

    localparam logic [1:0] LAT_WAIT  = 2'(RDLAT - 1);
    localparam logic [1:0] TURN_WAIT = 2'(TURN_CYCLES - 1);

    state_e        state_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_last_q;
    logic          mem_oe_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] cur_addr_q;
    logic [AW-1:0] len_q;
    logic [AW:0]   beat_q;
    logic [1:0]    wait_q;

    logic accept;
    logic wr_start_d;
    logic last_beat;

    assign accept     = req_valid && req_ready_q;
    assign wr_start_d = accept && req_write;
    // Beat counter is one bit wider than len so len=15 yields 16 beats.
    assign last_beat  = (beat_q == {1'b0, len_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_addr_q  <= '0;
            cur_addr_q  <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            wait_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        mem_addr_q  <= req_addr;
                        cur_addr_q  <= req_addr;
                        len_q       <= req_len;
                        beat_q      <= '0;
                        state_q     <= req_write ? WR : RD_ISSUE;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WR: begin
                    wait_q  <= TURN_WAIT;
                    state_q <= TURN;
                end
                TURN: begin
                    if (wait_q == 2'd0) begin
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                RD_ISSUE: begin
                    mem_oe_q   <= 1'b1;
                    mem_addr_q <= cur_addr_q;
                    wait_q     <= LAT_WAIT;
                    state_q    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_q == 2'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_data;
                        rsp_last_q  <= last_beat;
                        state_q     <= RD_HOLD;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                RD_HOLD: begin
                    // The accepting edge already issues the next address.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        beat_q      <= beat_q + (AW+1)'(1);
                        if (rsp_last_q) begin
                            mem_oe_q <= 1'b0;
                            wait_q   <= TURN_WAIT;
                            state_q  <= TURN;
                        end else begin
                            cur_addr_q <= cur_addr_q + AW'(1);
                            mem_addr_q <= cur_addr_q + AW'(1);
                            wait_q     <= LAT_WAIT;
                            state_q    <= RD_WAIT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_bus_tristate #(.DW(DW)) u_tristate (
        .clk         (clk),
        .rst         (rst),
        .wr_start_i  (wr_start_d),
        .wdata_i     (req_wdata),
        .we_o        (mem_we),
        .mem_data_io (mem_data)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q != IDLE);
    assign mem_oe    = mem_oe_q;
    assign mem_addr  = mem_addr_q;

endmodule
